tx_gearbox_10b: RTL
===================

Name: tx_gearbox_10b

Overview:
- Transmit stage directly downstream of the 8b/10b encoder. It takes 10-bit code groups over a valid/ready handshake and emits them as a continuous OUT_W-bit-per-cycle stream to the SERDES/PHY transmit lane.
- Default OUT_W=1 makes it a bit-serial serializer. Wider settings act as a 10:OUT_W gearbox.
- Transmission order is bit 0 (code bit 'a') first. It detects and counts underruns.

Parameters:
- OUT_W, 1, output bits per clock; legal range 1..10, elaboration error outside it.
- UCNT_W, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  10  code group; bit 0 is transmitted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- ser_out  out  OUT_W  output bits; ser_out[0] is the earliest bit in time.
- ser_valid  out  1  ser_out carries real data this cycle.
- underrun  out  1  one-cycle pulse: an output slot was starved.
- underrun_cnt  out  UCNT_W  saturating count of underrun cycles.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge.
- Reset values:
  - buffer = 0; fill count cnt = 0; started = 0.
  - ser_out = 0; ser_valid = 0; underrun = 0; underrun_cnt = 0.
  - in_ready is forced to 0 while rst_n = 0.
- Storage: 20-bit shift buffer buf, with valid bits in buf[cnt-1:0] and the oldest bit at buf[0]. The fill count cnt (5 bits) ranges 0..20.
- Per-cycle evaluation:
  - take = (cnt >= OUT_W).
  - rem = cnt - (take ? OUT_W : 0).
  - in_ready = (rem <= 10), combinational from registers only. It never depends on in_valid.
- Accept: a word is accepted when in_valid && in_ready at the rising edge.
  - buf_next = (buf >> (take ? OUT_W : 0)) | (in_data << rem).
  - cnt_next = rem + 10.
- No accept: buf shifts by the taken amount; cnt_next = rem.
- Output: registered.
  - If take: ser_out <= buf[OUT_W-1:0], ser_valid <= 1.
  - Else: ser_out <= 0, ser_valid <= 0.
- Latency: a word accepted at edge t, with cnt = 0 before the edge, has its first OUT_W bits on ser_out after edge t+1.
- Bits of consecutive words are concatenated with no gaps. A word may straddle two output beats, e.g. OUT_W=4 places bits 8,9 of word N and bits 0,1 of word N+1 in one beat.
- started: set on the first accept after reset; never cleared except by reset.
- Underrun: when started && !take in a cycle:
  - underrun <= 1 for that cycle; otherwise 0.
  - underrun_cnt increments, saturating at all-ones.
  - The partial residue (cnt < OUT_W) is kept and emitted once enough bits arrive. Nothing is dropped or padded.
- Simultaneous take and accept in the same cycle is the normal streaming case and must sustain full throughput.
- If in_valid is held high continuously, there is never an underrun once started.
- Reset mid-stream: all buffered bits are discarded, started is cleared, and counters are zeroed. in_data presented during reset is ignored.
- cnt never exceeds 20. Overflow is structurally impossible by the in_ready rule; add an assertion for it.

Optional Feature:
- Macro: TX_GEARBOX_MSB_FIRST_EN.
- Defined: each accepted word is bit-reversed before insertion, so in_data[9] is transmitted first. All other timing is identical.
- Undefined: bit 0 first, as above.

Decomposition:
- Shared package serdes_8b10b_pkg holds:
  - SYM_W = 10 and GB_BUF_W = 20.
  - GB_CNT_W = $clog2(GB_BUF_W+1).
  - A bit-reverse function for SYM_W vectors.
- No sub-module; the block is a single module.

Test Plan:
- Bit order, OUT_W=1: after reset, single word 10'h17C → ser_out sequence 0,0,1,1,1,1,1,0,1,0 over 10 cycles starting the cycle after accept, ser_valid high throughout. Then underrun pulses every cycle and underrun_cnt counts 1,2,3…
- Back-to-back streaming, OUT_W=1: in_valid held high with words 10'h3FF, 10'h000, 10'h155, 10'h2AA.
  - in_ready pulses once per 10 cycles.
  - ser_out output is 10 ones, 10 zeros, then alternating bits.
  - underrun is never asserted.
- Straddling, OUT_W=4: words 10'h3FF then 10'h000 back to back → ser_out beats 4'hF, 4'hF, 4'h3, 4'h0, 4'h0. in_ready is low in the cycle where cnt = 16.
- Mid-stream reset: pulse rst_n low for 1 cycle after 5 bits of 10'h2AA have been sent → next cycle ser_valid = 0 and underrun_cnt = 0. No residue is emitted after a new word is accepted; the new word starts at its bit 0.
- Saturation, with UCNT_W overridden to 4: 20 starved cycles after the first word → underrun_cnt sticks at 4'hF.
- Macro TX_GEARBOX_MSB_FIRST_EN defined, OUT_W=1: word 10'h17C → ser_out sequence 0,1,0,1,1,1,1,1,0,0.

Source files
------------

// File: rtl/serdes_8b10b_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serdes_8b10b_pkg : constants and helpers shared by the 8b/10b transmit path
// Revision: 1.0
// ---------------------------------------------------------------------------
package serdes_8b10b_pkg;

  localparam int SYM_W    = 10;
  localparam int GB_BUF_W = 20;
  localparam int GB_CNT_W = $clog2(GB_BUF_W + 1);

  function automatic logic [SYM_W-1:0] bit_rev(input logic [SYM_W-1:0] sym);
    logic [SYM_W-1:0] r;
    r = '0;
    for (int i = 0; i < SYM_W; i++) begin
      r[i] = sym[SYM_W-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_gearbox_10b.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_gearbox_10b : 10-bit code groups to a gap-free OUT_W-bit lane stream
// Macro TX_GEARBOX_MSB_FIRST_EN: send in_data[9] first instead of bit 0.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_gearbox_10b
  import serdes_8b10b_pkg::*;
#(
  parameter int OUT_W  = 1,
  parameter int UCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  ser_out,
  output logic              ser_valid,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  generate
    if (OUT_W < 1 || OUT_W > SYM_W) begin : g_bad_out_w
      $error("tx_gearbox_10b: OUT_W must be in 1..10");
    end
  endgenerate

  localparam logic [GB_CNT_W-1:0] c_out_w = GB_CNT_W'(OUT_W);
  localparam logic [GB_CNT_W-1:0] c_sym_w = GB_CNT_W'(SYM_W);
  localparam logic [GB_CNT_W-1:0] c_buf_w = GB_CNT_W'(GB_BUF_W);

  logic [GB_BUF_W-1:0] buf_q, buf_d;
  logic [GB_CNT_W-1:0] cnt_q, cnt_d;
  logic                started_q, started_d;
  logic [OUT_W-1:0]    ser_out_q, ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic                underrun_q, underrun_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;

  logic                w_take;
  logic                w_accept;
  logic [GB_CNT_W-1:0] w_rem;
  logic [SYM_W-1:0]    w_sym;
  logic [GB_BUF_W-1:0] w_shifted;
  logic [GB_BUF_W-1:0] w_ins;

`ifdef TX_GEARBOX_MSB_FIRST_EN
  assign w_sym = bit_rev(in_data);
`else
  assign w_sym = in_data;
`endif

  // Ready looks at the post-take fill level so take and accept can overlap.
  assign w_take    = (cnt_q >= c_out_w);
  assign w_rem     = w_take ? (cnt_q - c_out_w) : cnt_q;
  assign in_ready  = rst_n && (w_rem <= c_sym_w);
  assign w_accept  = in_valid && in_ready;
  assign w_shifted = w_take ? (buf_q >> OUT_W) : buf_q;
  assign w_ins     = {{(GB_BUF_W-SYM_W){1'b0}}, w_sym} << w_rem;

  always_comb begin
    buf_d       = w_shifted;
    cnt_d       = w_rem;
    started_d   = started_q;
    if (w_accept) begin
      buf_d     = w_shifted | w_ins;
      cnt_d     = w_rem + c_sym_w;
      started_d = 1'b1;
    end
    ser_out_d   = w_take ? buf_q[OUT_W-1:0] : '0;
    ser_valid_d = w_take;
    underrun_d  = started_q && !w_take;
    ucnt_d      = ucnt_q;
    if (underrun_d && (ucnt_q != {UCNT_W{1'b1}})) begin
      ucnt_d = ucnt_q + UCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      started_q   <= 1'b0;
      ser_out_q   <= '0;
      ser_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      started_q   <= started_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_q <= c_buf_w);
    end
  end

  assign ser_out      = ser_out_q;
  assign ser_valid    = ser_valid_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule
`default_nettype wire
